block_data_memory: RTL and testbench
====================================

# block_data_memory

Backing data memory sitting directly downstream of the data cache on the cache's main-memory port. Stores whole 128-bit cache blocks addressed by a 28-bit block address. Serves one block read or one block write per request with a fixed multi-cycle latency, signalled through a busywait handshake. The cache miss and write-back FSM consumes that handshake.

## Interface
- DEPTH, 256: number of 128-bit blocks stored; power of two, ≥2
- LATENCY, 5: cycles busywait stays high per access, counted from the request cycle; ≥2
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- read  input  1  block read request, held until the access completes
- write  input  1  block write request, held until the access completes
- address  input  28  block address; only address[log2(DEPTH)-1:0] is used
- writedata  input  128  block to store; sampled when the request is accepted
- readdata  output  128  block returned by the most recent completed read
- busywait  output  1  high while an access is in progress

## Operation
- Storage is an array of DEPTH × 128-bit blocks, indexed by the address low bits. Upper address bits are ignored, so addresses alias modulo DEPTH.
- Array contents are not affected by reset. At simulation start they are initialised to zero.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Valid request is exactly one of read or write high.
  - Valid request: busywait = 1 combinationally in the same cycle. On the next edge, latch address index, access type and writedata, load the countdown with LATENCY-1, and go to BUSY.
  - read and write both high, or neither high: busywait = 0 and stay in IDLE. The both-high case is an illegal request and is ignored.
- BUSY:
  - busywait = 1.
  - Decrement the countdown each edge.
  - On the edge where the countdown equals 1, go to DONE. On that same edge:
    - read: readdata <= array[latched index].
    - write: array[latched index] <= latched writedata.
- DONE:
  - busywait = 0 for exactly one cycle.
  - Go to IDLE on the next edge unconditionally. A request held during DONE is not re-accepted in DONE.
- Requests are latched, so changes to address or writedata after acceptance have no effect.
- A request dropped during BUSY still completes. The write commits, or readdata updates, on schedule.
- readdata changes only at a read completion or reset. It is unaffected by writes, including writes to the same index.
- Reset asserted at any time:
  - State → IDLE, countdown → 0, busywait → 0, readdata → 0.
  - Any in-flight access is abandoned; a pending write is not committed.
  - While reset is low, requests are ignored.

## Timing
- Reset values: busywait 0, readdata 128'h0, state IDLE.
- Request asserted in cycle 1 while in IDLE:
  - busywait is high in cycles 1 through LATENCY.
  - Cycle LATENCY+1 is DONE: busywait low, readdata valid for a read, write visible.
  - The cache commits the read block on the edge ending DONE.
- Back-to-back access:
  - A request still asserted, or newly asserted, in the cycle after DONE is accepted as a new access.
  - This matches the cache's write-back then refill sequence.
  - Minimum spacing between completions is LATENCY+1 cycles.
- Reset deassertion takes effect asynchronously. The first request can be accepted at the first edge after reset goes high.

## Test plan
- Reset: hold reset low 2 cycles with read high → busywait 0 and readdata 0 throughout. After release, read of index 0x03 → 128'h0 after 5 busy cycles.
- Write then read:
  - Write address 0x0000005 with data 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D → busywait high exactly 5 cycles, then low 1 cycle.
  - Then read 0x0000005 → that value on readdata in its DONE cycle.
- Aliasing (DEPTH=256): write 128'h1111 to 0x0000105, then read 0x0000005 → 128'h1111. Also check that readdata holds its previous value through the write.
- Early drop: write 128'hAAAA to 0x0000010, and drop write after 2 cycles → busywait still completes 5 cycles. A subsequent read of 0x0000010 → 128'hAAAA.
- Reset mid-write:
  - Index 0x20 holds 128'h5555.
  - Issue a write of 128'h7777 and pulse reset low in busy cycle 3 → busywait drops immediately.
  - Read 0x20 after reset → 128'h5555.
- Write-back then refill: write to 0x0000040, with read to 0x0000080 asserted the cycle after DONE → busywait pattern 5 high, 1 low, 5 high, 1 low, and correct data for 0x80. Also assert read and write both high in IDLE → busywait stays 0 and the array is unchanged.

Source files
------------

// File: rtl/block_data_memory.sv
// Block-granular backing memory behind the data cache. Each access takes a
// fixed LATENCY cycles, reported through busywait, and is followed by one DONE cycle.
module block_data_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [27:0]  address,
    input  logic [127:0] writedata,
    output logic [127:0] readdata,
    output logic         busywait
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [IW-1:0]   req_idx;
    logic            req_write;
    logic [127:0]    req_data;
    logic [127:0]    mem [DEPTH];
    logic            valid_req;
    logic            last_beat;
    logic            unused_address;

    // Upper address bits alias onto the same block and are deliberately dropped.
    assign unused_address = ^address[27:IW];

    // Exactly one of read/write makes a request; both-high is illegal and ignored.
    assign valid_req = reset && (read != write);
    assign last_beat = (state == BUSY) && (count == COUNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (valid_req) state_next = BUSY;
            BUSY:    if (count == COUNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = valid_req;
            BUSY:    busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            req_idx   <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
            readdata  <= '0;
        end else if (state == IDLE && valid_req) begin
            count     <= COUNT_LOAD;
            req_idx   <= address[IW-1:0];
            req_write <= write;
            req_data  <= writedata;
        end else if (state == BUSY) begin
            count <= count - COUNT_LAST;
            if (last_beat && !req_write) begin
                readdata <= mem[req_idx];
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and only commits change them.
    // A reset drops state to IDLE asynchronously, so an abandoned write never reaches last_beat.
    always_ff @(posedge clock) begin
        if (last_beat && req_write) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: a timestamp-based transaction model is
// compared against busywait/readdata every cycle, plus literal per-access checks.
module tb_block_data_memory;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 5;

    bit           clock = 1'b0;
    logic         reset;
    logic         read;
    logic         write;
    logic [27:0]  address;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         busywait;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    block_data_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: an access accepted in cycle t0 is busy through
    // t0+LATENCY-1 and completes (DONE) in cycle t0+LATENCY.
    bit [127:0] m_mem [DEPTH];
    bit [127:0] m_rd     = '0;
    bit         m_busy   = 1'b0;
    bit         m_active = 1'b0;
    bit         m_wr     = 1'b0;
    int         m_t0     = 0;
    int         m_idx    = 0;
    bit [127:0] m_data   = '0;

    always @(negedge clock) begin
        if (!reset) begin
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_rd     = '0;
        end else if (!m_active) begin
            m_busy = (read != write);
            if (m_busy) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_wr     = write;
                m_idx    = int'(address) % DEPTH;
                m_data   = writedata;
            end
        end else if (cyc < m_t0 + LATENCY) begin
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
            if (m_wr) m_mem[m_idx] = m_data;
            else      m_rd = m_mem[m_idx];
            m_active = 1'b0;
        end
        check("busywait_model", 128'(busywait), 128'(m_busy));
        check("readdata_model", readdata, m_rd);
    end

    // Issues one access in the next cycle and returns at the DONE cycle's negedge.
    // Address/data are scrambled after acceptance; hold>0 drops the request early.
    task automatic access(input bit wr, input logic [27:0] a, input logic [127:0] d,
                          input int hold, output int nbusy);
        bit done;
        @(posedge clock); #1;
        read      = !wr;
        write     = wr;
        address   = a;
        writedata = d;
        nbusy     = 0;
        done      = 1'b0;
        for (int i = 0; i < 4 * LATENCY; i++) begin
            @(negedge clock);
            if (!busywait) begin
                done = 1'b1;
                break;
            end
            nbusy++;
            if (nbusy == 2) begin
                address   = ~a;
                writedata = ~d;
            end
            if (hold > 0 && nbusy == hold) begin
                read  = 1'b0;
                write = 1'b0;
            end
        end
        if (!done) check("access_timeout", 128'(1), 128'(0));
        read  = 1'b0;
        write = 1'b0;
    endtask

    int nb;

    initial begin
        reset     = 1'b0;
        read      = 1'b1;
        write     = 1'b0;
        address   = 28'h0000003;
        writedata = '0;

        // Reset held with read high: nothing happens.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busywait", 128'(busywait), 128'(0));
        check("reset_readdata", readdata, 128'h0);
        @(posedge clock); #1;
        read  = 1'b0;
        reset = 1'b1;

        access(1'b0, 28'h0000003, '0, 0, nb);
        check("rd3_busy_cycles", 128'(nb), 128'(5));
        check("rd3_data", readdata, 128'h0);

        access(1'b1, 28'h0000005, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, nb);
        check("wr5_busy_cycles", 128'(nb), 128'(5));
        access(1'b0, 28'h0000005, '0, 0, nb);
        check("rd5_busy_cycles", 128'(nb), 128'(5));
        check("rd5_data", readdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

        // Aliasing: 0x105 maps onto index 0x05; readdata holds through the write.
        access(1'b1, 28'h0000105, 128'h1111, 0, nb);
        check("wr105_readdata_held", readdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        access(1'b0, 28'h0000005, '0, 0, nb);
        check("alias_rd5_data", readdata, 128'h1111);

        // Early drop still completes.
        access(1'b1, 28'h0000010, 128'hAAAA, 2, nb);
        check("drop_busy_cycles", 128'(nb), 128'(5));
        access(1'b0, 28'h0000010, '0, 0, nb);
        check("drop_rd10_data", readdata, 128'hAAAA);

        // Reset in busy cycle 3 of a write abandons it.
        access(1'b1, 28'h0000020, 128'h5555, 0, nb);
        @(posedge clock); #1;
        write     = 1'b1;
        address   = 28'h0000020;
        writedata = 128'h7777;
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        write = 1'b0;
        #1;
        check("midreset_busywait", 128'(busywait), 128'(0));
        @(negedge clock);
        check("midreset_readdata", readdata, 128'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        access(1'b0, 28'h0000020, '0, 0, nb);
        check("midreset_rd20_data", readdata, 128'h5555);

        // Write-back then refill, back to back.
        access(1'b1, 28'h0000080, 128'h8080, 0, nb);
        access(1'b1, 28'h0000040, 128'h4040, 0, nb);
        check("wb_busy_cycles", 128'(nb), 128'(5));
        access(1'b0, 28'h0000080, '0, 0, nb);
        check("refill_busy_cycles", 128'(nb), 128'(5));
        check("refill_rd80_data", readdata, 128'h8080);

        // Illegal both-high request is ignored.
        @(posedge clock); #1;
        read      = 1'b1;
        write     = 1'b1;
        address   = 28'h0000040;
        writedata = 128'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("both_high_busywait", 128'(busywait), 128'(0));
        end
        @(posedge clock); #1;
        read  = 1'b0;
        write = 1'b0;
        access(1'b0, 28'h0000040, '0, 0, nb);
        check("both_high_rd40_data", readdata, 128'h4040);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
